// File: rtl/fp_sub_if.sv
// Request/response bundle for the sequential single-precision subtractor.
interface fp_sub_if;
  logic        start;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, data1, data2, input busy, done, result);
  modport slave  (input start, data1, data2, output busy, done, result);
endinterface

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision data1 - data2 with truncation and denormal flush.
module fp_subtractor_seq (
  input  logic      clk,
  input  logic      rst_n,
  fp_sub_if.slave   bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned SUM_W  = 25;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t              state, state_next;
  logic                sign_a, eff_sub;
  logic [EXP_W-1:0]    exp_r, diff;
  logic [MANT_W-1:0]   mant_a, mant_b;
  logic [SUM_W-1:0]    sum;
  logic [WORD_W-1:0]   result_r;
  logic                busy_r, done_r;

  // Accept-time decode: subtrahend sign flip, magnitude ordering, zero bypass
  logic [EXP_W-1:0]    exp1, exp2, diff_in;
  logic [WORD_W-1:0]   neg2, op_a, op_b, zero_result;
  logic                zero_in, swap, norm_exit;

  assign exp1        = bus.data1[30:23];
  assign exp2        = bus.data2[30:23];
  assign neg2        = {~bus.data2[31], bus.data2[30:0]};
  assign zero_in     = (exp1 == '0) || (exp2 == '0);
  assign swap        = bus.data2[30:0] > bus.data1[30:0];
  assign op_a        = swap ? neg2 : bus.data1;
  assign op_b        = swap ? bus.data1 : neg2;
  assign diff_in     = op_a[30:23] - op_b[30:23];
  assign zero_result = (exp1 == '0 && exp2 == '0) ? '0 :
                       (exp2 == '0) ? bus.data1 : neg2;
  assign norm_exit   = (sum == '0) || sum[24] || sum[23] || (exp_r == EXP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (zero_in)              state_next = DONE;
          else if (diff_in != '0)   state_next = ALIGN;
          else                      state_next = ADD;
        end
      end
      ALIGN: if (diff > EXP_W'(24) || diff == EXP_W'(1)) state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  if (norm_exit) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a   <= 1'b0;
      eff_sub  <= 1'b0;
      exp_r    <= '0;
      diff     <= '0;
      mant_a   <= '0;
      mant_b   <= '0;
      sum      <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_next != IDLE);
      done_r <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (zero_in) begin
              result_r <= zero_result;
            end else begin
              sign_a  <= op_a[31];
              eff_sub <= op_a[31] ^ op_b[31];
              exp_r   <= op_a[30:23];
              mant_a  <= {1'b1, op_a[22:0]};
              mant_b  <= {1'b1, op_b[22:0]};
              diff    <= diff_in;
            end
          end
        end
        ALIGN: begin
          if (diff > EXP_W'(24)) begin
            mant_b <= '0;
            diff   <= '0;
          end else begin
            mant_b <= mant_b >> 1;
            diff   <= diff - EXP_W'(1);
          end
        end
        ADD: begin
          sum <= eff_sub ? ({1'b0, mant_a} - {1'b0, mant_b})
                         : ({1'b0, mant_a} + {1'b0, mant_b});
        end
        NORM: begin
          if (sum == '0) begin
            result_r <= '0;
          end else if (sum[24]) begin
            if (exp_r == EXP_W'(254)) result_r <= {sign_a, 8'hFF, 23'h0};
            else                      result_r <= {sign_a, exp_r + EXP_W'(1), sum[23:1]};
            exp_r <= exp_r + EXP_W'(1);
            sum   <= sum >> 1;
          end else if (sum[23]) begin
            result_r <= {sign_a, exp_r, sum[22:0]};
          end else if (exp_r == EXP_W'(1)) begin
            result_r <= '0;
          end else begin
            sum   <= sum << 1;
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: result and latency per operation, busy/done protocol, reset abort.
module tb_fp_subtractor_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t exp_q[$];

  fp_sub_if bus();

  fp_subtractor_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Reference: flip subtrahend sign, order by magnitude, align, add, normalise one step per cycle
  function automatic void model(input logic [31:0] d1, input logic [31:0] d2,
                                output logic [31:0] r, output int lat);
    logic [31:0] n2, a, b;
    logic [24:0] s, ma, mb;
    int e, diff;
    n2 = {~d2[31], d2[30:0]};
    lat = 1;
    r = 32'h0;
    if (d1[30:23] == 8'h0 && d2[30:23] == 8'h0) r = 32'h0;
    else if (d2[30:23] == 8'h0) r = d1;
    else if (d1[30:23] == 8'h0) r = n2;
    else begin
      if (d1[30:0] >= d2[30:0]) begin a = d1; b = n2; end
      else begin a = n2; b = d1; end
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      diff = int'(a[30:23]) - int'(b[30:23]);
      if (diff > 24) begin mb = 25'h0; lat += 1; end
      else begin mb = mb >> diff; lat += diff; end
      s = (a[31] == b[31]) ? ma + mb : ma - mb;
      lat += 1;
      e = int'(a[30:23]);
      for (int k = 0; k < 40; k++) begin
        lat += 1;
        if (s == 25'h0) begin r = 32'h0; break; end
        if (s[24]) begin
          if (e + 1 == 255) r = {a[31], 8'hFF, 23'h0};
          else r = {a[31], 8'(e + 1), s[23:1]};
          break;
        end
        if (s[23]) begin r = {a[31], 8'(e), s[22:0]}; break; end
        if (e == 1) begin r = 32'h0; break; end
        s = s << 1;
        e -= 1;
      end
    end
  endfunction

  function automatic logic [31:0] junk();
    return $urandom & 32'hBFFF_FFFF;
  endfunction

  // Drive one operation; optionally pulse start while busy, which must be ignored
  task automatic run_op(input logic [31:0] d1, input logic [31:0] d2, input bit poke);
    logic [31:0] er;
    int el, edges;
    bit seen, run_ok;
    exp_t e;
    model(d1, d2, er, el);
    exp_q.push_back('{res: er, lat: 32'(el)});
    @(negedge clk);
    bus.data1 = d1;
    bus.data2 = d2;
    bus.start = 1'b1;
    edges = 0;
    seen = 1'b0;
    run_ok = 1'b1;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      bus.start = 1'b0;
      bus.data1 = junk();
      bus.data2 = junk();
      if (bus.done) seen = 1'b1;
      else begin
        if (!bus.busy) run_ok = 1'b0;
        if (poke && edges == 1) bus.start = 1'b1;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("busy_run", 32'(run_ok), 32'd1);
    check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("result", bus.result, e.res);
      check_eq("latency", 32'(edges), e.lat);
    end
    check_eq("busy_at_done", 32'(bus.busy), 32'd1);
    if (poke) bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq("done_pulse", 32'(bus.done), 32'd0);
    check_eq("busy_idle", 32'(bus.busy), 32'd0);
    check_eq("result_hold", bus.result, er);
  endtask

  initial begin
    bit got_done;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.data1 = 32'h0;
    bus.data2 = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_result", bus.result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h4040_0000, 32'h3F80_0000, 1'b0);
    check_eq("r029", bus.result, 32'h4000_0000);

    // Abort during NORM of 3.0 - 1.0
    @(negedge clk);
    bus.data1 = 32'h4040_0000;
    bus.data2 = 32'h3F80_0000;
    bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_result", bus.result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) got_done = 1'b1;
    end
    check_eq("abort_no_done", 32'(got_done), 32'd0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b0);
    check_eq("r034", bus.result, 32'h4000_0000);

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    check_eq("r030", bus.result, 32'h0000_0000);
    run_op(32'h0000_0000, 32'h40A0_0000, 1'b1);
    check_eq("r031", bus.result, 32'hC0A0_0000);
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b0);
    check_eq("r032", bus.result, 32'h7F80_0000);
    run_op(32'h4B80_0000, 32'h3F80_0000, 1'b1);
    check_eq("r033", bus.result, 32'h4B80_0000);

    run_op(32'h3FC0_0000, 32'h3FA0_0000, 1'b0);  // 1.5 - 1.25: two left shifts
    check_eq("cancel", bus.result, 32'h3E80_0000);
    run_op(32'h4E80_0000, 32'h3F80_0000, 1'b0);  // diff 30: mantB cleared
    check_eq("far_align", bus.result, 32'h4E80_0000);
    run_op(32'h00C0_0000, 32'h0080_0000, 1'b0);  // underflow to zero
    check_eq("underflow", bus.result, 32'h0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b0);  // 1 - 3 = -2
    check_eq("neg", bus.result, 32'hC000_0000);
    run_op(32'h3F80_0000, 32'hBF80_0000, 1'b0);  // 1 - (-1) = 2
    check_eq("add", bus.result, 32'h4000_0000);
    run_op(32'h4120_0000, 32'h0000_0000, 1'b0);
    check_eq("sub_zero", bus.result, 32'h4120_0000);
    run_op(32'h8000_0000, 32'h0000_1234, 1'b0);
    check_eq("both_zero", bus.result, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a = {1'($urandom), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
      b = {1'($urandom), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
      if (i % 4 == 1) b[30:23] = a[30:23];
      if (i % 9 == 3) b[30:23] = 8'h0;
      run_op(a, b, 1'(i % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_subtractor_seq.md
FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

Interface
REQ-001 The block SHALL have no parameters; operand format SHALL be fixed IEEE-754 single precision.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 data1  input  32  minuend; sampled on the accept edge.
REQ-006 data2  input  32  subtrahend; sampled on the accept edge.
REQ-007 busy  output  1  high from the cycle after accept until the done cycle inclusive.
REQ-008 done  output  1  one-cycle pulse; result is valid from this cycle on.
REQ-009 result  output  32  registered data1 - data2; held until the next done.

Function
REQ-010 The block SHALL compute data1 - data2 by inverting the data2 sign bit, then performing sign-magnitude addition.
REQ-011 FSM states SHALL be IDLE, ALIGN, ADD, NORM and DONE; busy SHALL be 0 only in IDLE.
REQ-012 start while busy=1 SHALL be ignored without side effects; inputs SHALL be don't-care outside the accept edge.
REQ-013 An operand with exponent 0 SHALL be treated as zero (denormals flushed); exponent-255 inputs are unsupported and SHALL NOT be driven by the bench.
REQ-014 Zero path, IDLE -> DONE directly:
- both zero: result 32'h0
- data2 zero: result data1
- data1 zero: result data2 with bit 31 inverted
REQ-015 Otherwise, at accept:
- A = the operand with larger {exp, mantissa} magnitude (data1 on a tie); B = the other
- mantissas widened to 24 bits with hidden 1
- diff = expA - expB
REQ-016 On accept, the next state SHALL be ALIGN if diff != 0, else ADD.
REQ-017 ALIGN SHALL shift mantB right one bit and decrement diff each cycle; it SHALL go to ADD when diff reaches 0.
REQ-018 If diff > 24 at entry, ALIGN SHALL clear mantB and go to ADD in one cycle.
REQ-019 ADD SHALL take one cycle:
- 25-bit sum = mantA + mantB when effective signs are equal, else mantA - mantB (never negative)
- result sign = sign of A
- next state NORM
REQ-020 Rounding SHALL be truncation; no guard, round or sticky bits.
REQ-021 NORM, one check per cycle:
- sum == 0: result 32'h0 (+0), go to DONE
- sum[24] set: shift right 1, exp+1, go to DONE
- sum[23] set: pack {sign, exp, sum[22:0]}, go to DONE
- else: shift left 1, exp-1, stay in NORM
REQ-022 NORM underflow: if exp == 1 and sum[23] == 0, result SHALL be 32'h0.
REQ-023 NORM overflow: an exp increment reaching 255 SHALL give result {sign, 8'hFF, 23'h0}.
REQ-024 result SHALL be written on the edge that enters DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE; a new start is accepted no earlier than the following IDLE cycle.
REQ-026 Latency, counted in edges from the accept edge to done high:
- zero path: 1
- otherwise: 1 + min(diff, 1 if diff>24) + 1 + NORM cycles

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=32'h0 and clear all internal registers, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL be processed normally.

Verification
REQ-029 data1=32'h40400000 (3.0), data2=32'h3F800000 (1.0) -> done at edge 4, result=32'h40000000 (2.0).
REQ-030 data1=32'h3F800000, data2=32'h3F800000 -> done at edge 3, result=32'h00000000.
REQ-031 data1=32'h00000000, data2=32'h40A00000 -> done at edge 1, result=32'hC0A00000; start pulsed during busy is ignored.
REQ-032 data1=32'h7F7FFFFF, data2=32'hFF7FFFFF -> result=32'h7F800000 (+inf).
REQ-033 data1=32'h4B800000 (2^24), data2=32'h3F800000 -> ALIGN completes (diff=24), result=32'h4B800000 after truncation.
REQ-034 rst_n pulsed low during NORM of case REQ-029 -> busy/done/result all 0 immediately; no done; a repeat of REQ-029 then passes.
